lcd_timing_gen: RTL and testbench



---
 rtl/lcd_pkg.sv | 31 +++
 rtl/lcd_sync_cnt.sv | 39 +++
 rtl/lcd_timing_gen.sv | 121 ++++++++++++
 tb/tb_lcd_timing_gen.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared LCD definitions: panel timing sets and RGB888 colour constants
// used by both the timing generator and the display/pattern stage.
package lcd_pkg;

  typedef logic [23:0] rgb888_t;

  typedef struct packed {
    int unsigned h_sync;
    int unsigned h_back;
    int unsigned h_disp;
    int unsigned h_front;
    int unsigned v_sync;
    int unsigned v_back;
    int unsigned v_disp;
    int unsigned v_front;
  } lcd_timing_t;

  localparam lcd_timing_t TIMING_800X480  = '{h_sync: 128, h_back: 88, h_disp: 800, h_front: 40,
                                              v_sync: 2,   v_back: 33, v_disp: 480, v_front: 10};
  localparam lcd_timing_t TIMING_480X272  = '{h_sync: 41,  h_back: 2,  h_disp: 480, h_front: 2,
                                              v_sync: 10,  v_back: 2,  v_disp: 272, v_front: 2};
  localparam lcd_timing_t TIMING_1024X600 = '{h_sync: 20,  h_back: 140, h_disp: 1024, h_front: 160,
                                              v_sync: 3,   v_back: 20,  v_disp: 600,  v_front: 12};

  localparam rgb888_t RGB_BLACK = 24'h000000;
  localparam rgb888_t RGB_WHITE = 24'hFFFFFF;
  localparam rgb888_t RGB_RED   = 24'hFF0000;
  localparam rgb888_t RGB_GREEN = 24'h00FF00;
  localparam rgb888_t RGB_BLUE  = 24'h0000FF;

endpackage

// File: rtl/lcd_sync_cnt.sv
// Wrapping 11-bit raster counter with sync and active-window decode.
// Used once for the horizontal axis (every pclk) and once for the vertical
// axis (advanced on horizontal wrap).
module lcd_sync_cnt #(
  parameter int unsigned SYNC  = 1,
  parameter int unsigned BACK  = 1,
  parameter int unsigned DISP  = 1,
  parameter int unsigned FRONT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [10:0] cnt,
  output logic        sync_act,
  output logic        disp_act
);

  localparam int unsigned TOTAL  = SYNC + BACK + DISP + FRONT;
  localparam logic [10:0] LAST_C = 11'(TOTAL - 1);
  localparam logic [10:0] SYNC_C = 11'(SYNC);
  localparam logic [10:0] ACT_LO = 11'(SYNC + BACK);
  localparam logic [10:0] ACT_HI = 11'(SYNC + BACK + DISP);

  // Count 0..TOTAL-1 on each enable, wrapping to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST_C) ? '0 : cnt + 11'd1;
    end
  end

  // Window decodes on the current count.
  always_comb begin
    sync_act = (cnt < SYNC_C);
    disp_act = (cnt >= ACT_LO) && (cnt < ACT_HI);
  end

endmodule

// File: rtl/lcd_timing_gen.sv
// RGB LCD raster timing generator. Produces HS/VS/DE from porch counts and
// requests pixels one pclk ahead of DE so a registered display stage
// returns pixel_data aligned with lcd_de.
module lcd_timing_gen
  import lcd_pkg::*;
#(
  parameter int unsigned H_SYNC   = TIMING_800X480.h_sync,
  parameter int unsigned H_BACK   = TIMING_800X480.h_back,
  parameter int unsigned H_DISP   = TIMING_800X480.h_disp,
  parameter int unsigned H_FRONT  = TIMING_800X480.h_front,
  parameter int unsigned V_SYNC   = TIMING_800X480.v_sync,
  parameter int unsigned V_BACK   = TIMING_800X480.v_back,
  parameter int unsigned V_DISP   = TIMING_800X480.v_disp,
  parameter int unsigned V_FRONT  = TIMING_800X480.v_front,
  parameter int unsigned SYNC_POL = 0
) (
  input  logic        lcd_pclk,
  input  logic        rst_n,
  input  logic [23:0] pixel_data,
  output logic [10:0] pixel_xpos,
  output logic [10:0] pixel_ypos,
  output logic [10:0] h_disp,
  output logic [10:0] v_disp,
  output logic        lcd_hs,
  output logic        lcd_vs,
  output logic        lcd_de,
  output logic [23:0] lcd_rgb,
  output logic        frame_start
);

  localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
  localparam int unsigned HA      = H_SYNC + H_BACK;
  localparam int unsigned VA      = V_SYNC + V_BACK;

  localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
  localparam logic [10:0] REQ_LO  = 11'(HA - 1);
  localparam logic [10:0] REQ_HI  = 11'(HA + H_DISP - 1);
  localparam logic [10:0] VA_C    = 11'(VA);
  localparam logic        POL     = (SYNC_POL != 0);

  if (H_SYNC < 1 || V_SYNC < 1 || HA < 1) begin : g_bad_sync
    $error("lcd_timing_gen: H_SYNC, V_SYNC and H_SYNC+H_BACK must be >= 1");
  end
  if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_bad_total
    $error("lcd_timing_gen: line/frame totals must fit an 11-bit counter");
  end

  logic [10:0] h_cnt;
  logic [10:0] v_cnt;
  logic        h_sync_act;
  logic        h_disp_act;
  logic        v_sync_act;
  logic        v_disp_act;
  logic        h_last;
  logic        req;

  assign h_last = (h_cnt == H_LAST);

  lcd_sync_cnt #(
    .SYNC  (H_SYNC),
    .BACK  (H_BACK),
    .DISP  (H_DISP),
    .FRONT (H_FRONT)
  ) u_h_cnt (
    .clk      (lcd_pclk),
    .rst_n    (rst_n),
    .en       (1'b1),
    .cnt      (h_cnt),
    .sync_act (h_sync_act),
    .disp_act (h_disp_act)
  );

  lcd_sync_cnt #(
    .SYNC  (V_SYNC),
    .BACK  (V_BACK),
    .DISP  (V_DISP),
    .FRONT (V_FRONT)
  ) u_v_cnt (
    .clk      (lcd_pclk),
    .rst_n    (rst_n),
    .en       (h_last),
    .cnt      (v_cnt),
    .sync_act (v_sync_act),
    .disp_act (v_disp_act)
  );

  // Request window starts one column before the active window so the
  // display stage's one-cycle latency lands data on lcd_de.
  always_comb begin
    req = (h_cnt >= REQ_LO) && (h_cnt < REQ_HI) && v_disp_act;
  end

  // Register all raster outputs from the current counter position.
  always_ff @(posedge lcd_pclk or negedge rst_n) begin
    if (!rst_n) begin
      lcd_hs      <= ~POL;
      lcd_vs      <= ~POL;
      lcd_de      <= 1'b0;
      frame_start <= 1'b0;
      pixel_xpos  <= '0;
      pixel_ypos  <= '0;
    end else begin
      lcd_hs      <= h_sync_act ~^ POL;
      lcd_vs      <= v_sync_act ~^ POL;
      lcd_de      <= h_disp_act && v_disp_act;
      frame_start <= (h_cnt == '0) && (v_cnt == '0);
      pixel_xpos  <= req ? (h_cnt - REQ_LO) : '0;
      pixel_ypos  <= req ? (v_cnt - VA_C) : '0;
    end
  end

  // Blank the colour bus outside the active area.
  always_comb begin
    lcd_rgb = lcd_de ? pixel_data : RGB_BLACK;
  end

  assign h_disp = 11'(H_DISP);
  assign v_disp = 11'(V_DISP);

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Directed bench for lcd_timing_gen: small 14x7 raster plus a default
// 800x480 active-high instance for sync widths and constants.
module tb_lcd_timing_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] pixel_data = '0;

  logic [10:0] xpos, ypos, hdisp, vdisp;
  logic        hs, vs, de, fs;
  logic [23:0] rgb;

  logic [10:0] b_xpos, b_ypos, b_hdisp, b_vdisp;
  logic        b_hs, b_vs, b_de, b_fs;
  logic [23:0] b_rgb;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lcd_timing_gen #(
    .H_SYNC(2), .H_BACK(2), .H_DISP(8), .H_FRONT(2),
    .V_SYNC(1), .V_BACK(1), .V_DISP(4), .V_FRONT(1),
    .SYNC_POL(0)
  ) dut (
    .lcd_pclk(clk), .rst_n(rst_n), .pixel_data(pixel_data),
    .pixel_xpos(xpos), .pixel_ypos(ypos), .h_disp(hdisp), .v_disp(vdisp),
    .lcd_hs(hs), .lcd_vs(vs), .lcd_de(de), .lcd_rgb(rgb), .frame_start(fs)
  );

  lcd_timing_gen #(
    .SYNC_POL(1)
  ) dut_big (
    .lcd_pclk(clk), .rst_n(rst_n), .pixel_data(pixel_data),
    .pixel_xpos(b_xpos), .pixel_ypos(b_ypos), .h_disp(b_hdisp), .v_disp(b_vdisp),
    .lcd_hs(b_hs), .lcd_vs(b_vs), .lcd_de(b_de), .lcd_rgb(b_rgb), .frame_start(b_fs)
  );

  function automatic logic [23:0] pix(input int col, input int row);
    logic [7:0] r, g, b;
    r = 8'(col * 17 + 1);
    g = 8'(row * 40 + 3);
    b = 8'hA5 ^ 8'(col + row);
    return {r, g, b};
  endfunction

  // Display stage model: registered response to the requested position.
  always @(posedge clk) pixel_data <= pix(int'(xpos), int'(ypos));

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  typedef struct {
    int k;
    int fs, hs, vs, de, x, y;
  } vec_t;

  vec_t tbl[15];

  int lg_fs[0:299], lg_hs[0:299], lg_vs[0:299], lg_de[0:299], lg_x[0:299], lg_y[0:299];

  // Run n edges after a reset release, logging outputs and checking DE/RGB
  // against the raster position reached at edge k.
  task automatic run_frames(input int n);
    for (int k = 1; k <= n; k++) begin
      int h, v, de_e, rgb_e;
      @(posedge clk);
      #1;
      lg_fs[k] = int'(fs); lg_hs[k] = int'(hs); lg_vs[k] = int'(vs);
      lg_de[k] = int'(de); lg_x[k] = int'(xpos); lg_y[k] = int'(ypos);
      h = (k - 1) % 14;
      v = ((k - 1) / 14) % 7;
      de_e  = (h >= 4 && h <= 11 && v >= 2 && v <= 5) ? 1 : 0;
      rgb_e = de_e ? int'(pix(h - 4, v - 2)) : 0;
      chk($sformatf("de k=%0d", k), int'(de), de_e);
      chk($sformatf("rgb k=%0d", k), int'(rgb), rgb_e);
    end
  endtask

  task automatic apply_table();
    for (int i = 0; i < 15; i++) begin
      int k;
      k = tbl[i].k;
      chk($sformatf("tbl fs k=%0d", k), lg_fs[k], tbl[i].fs);
      chk($sformatf("tbl hs k=%0d", k), lg_hs[k], tbl[i].hs);
      chk($sformatf("tbl vs k=%0d", k), lg_vs[k], tbl[i].vs);
      chk($sformatf("tbl de k=%0d", k), lg_de[k], tbl[i].de);
      chk($sformatf("tbl xpos k=%0d", k), lg_x[k], tbl[i].x);
      chk($sformatf("tbl ypos k=%0d", k), lg_y[k], tbl[i].y);
    end
  endtask

  task automatic sequence_checks();
    int cnt;
    // frame_start at edges 1, 99, 197
    cnt = 0;
    for (int k = 1; k <= 200; k++) cnt += lg_fs[k];
    chk("frame_start count", cnt, 3);
    chk("frame_start k=197", lg_fs[197], 1);
    cnt = 0;
    for (int k = 1; k <= 14; k++) cnt += (lg_hs[k] == 0) ? 1 : 0;
    chk("hs low per line", cnt, 2);
    cnt = 0;
    for (int k = 1; k <= 98; k++) cnt += (lg_vs[k] == 0) ? 1 : 0;
    chk("vs low per frame", cnt, 14);
    // Line v=2: xpos 0..7 on edges 32..39, de on edges 33..40
    for (int i = 0; i < 8; i++) chk($sformatf("line xpos %0d", i), lg_x[32 + i], i);
    cnt = 0;
    for (int k = 29; k <= 42; k++) cnt += lg_de[k];
    chk("de per line", cnt, 8);
    // Rows: ypos at request start of v=2..5
    for (int v = 2; v <= 5; v++) chk($sformatf("ypos row v=%0d", v), lg_y[v * 14 + 4], v - 2);
    // Lines v=0,1,6: no activity on xpos/ypos/de
    cnt = 0;
    for (int k = 1; k <= 28; k++) cnt += lg_de[k] + lg_x[k] + lg_y[k];
    for (int k = 85; k <= 98; k++) cnt += lg_de[k] + lg_x[k] + lg_y[k];
    chk("idle lines activity", cnt, 0);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, " de"}, int'(de), 0);
    chk({tag, " xpos"}, int'(xpos), 0);
    chk({tag, " ypos"}, int'(ypos), 0);
    chk({tag, " hs"}, int'(hs), 1);
    chk({tag, " vs"}, int'(vs), 1);
    chk({tag, " fs"}, int'(fs), 0);
    chk({tag, " rgb"}, int'(rgb), 0);
  endtask

  initial begin
    int found, cnt_hs, cnt_vs;
    //            k   fs hs vs de x  y
    tbl[0]  = '{1,   1, 0, 0, 0, 0, 0};
    tbl[1]  = '{2,   0, 0, 0, 0, 0, 0};
    tbl[2]  = '{3,   0, 1, 0, 0, 0, 0};
    tbl[3]  = '{14,  0, 1, 0, 0, 0, 0};
    tbl[4]  = '{15,  0, 0, 1, 0, 0, 0};
    tbl[5]  = '{18,  0, 1, 1, 0, 0, 0};
    tbl[6]  = '{32,  0, 1, 1, 0, 0, 0};
    tbl[7]  = '{33,  0, 1, 1, 1, 1, 0};
    tbl[8]  = '{39,  0, 1, 1, 1, 7, 0};
    tbl[9]  = '{40,  0, 1, 1, 1, 0, 0};
    tbl[10] = '{41,  0, 1, 1, 0, 0, 0};
    tbl[11] = '{47,  0, 1, 1, 1, 1, 1};
    tbl[12] = '{76,  0, 1, 1, 1, 2, 3};
    tbl[13] = '{88,  0, 1, 1, 0, 0, 0};
    tbl[14] = '{99,  1, 0, 0, 0, 0, 0};

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_checks("reset");
    chk("h_disp", int'(hdisp), 8);
    chk("v_disp", int'(vdisp), 4);

    @(negedge clk) rst_n = 1'b1;
    run_frames(200);
    apply_table();
    sequence_checks();

    // Mid-line asynchronous reset at xpos=5
    found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      @(posedge clk);
      #1;
      if (xpos == 11'd5) found = 1;
    end
    chk("wait xpos=5", found, 1);
    chk("de before mid reset", int'(de), 1);
    #2 rst_n = 1'b0;
    #1;
    reset_checks("mid reset");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    run_frames(200);
    apply_table();
    sequence_checks();

    // Default 800x480, active-high syncs
    @(negedge clk) rst_n = 1'b0;
    #1;
    chk("big hs reset", int'(b_hs), 0);
    chk("big vs reset", int'(b_vs), 0);
    chk("big h_disp", int'(b_hdisp), 800);
    chk("big v_disp", int'(b_vdisp), 480);
    @(negedge clk) rst_n = 1'b1;
    cnt_hs = 0;
    cnt_vs = 0;
    for (int k = 1; k <= 2200; k++) begin
      @(posedge clk);
      #1;
      if (k <= 1056) cnt_hs += int'(b_hs);
      cnt_vs += int'(b_vs);
      if (k == 1) chk("big fs first edge", int'(b_fs), 1);
      if (k == 1057) chk("big hs restart line", int'(b_hs), 1);
    end
    chk("big hs high per line", cnt_hs, 128);
    chk("big vs high pclk", cnt_vs, 2112);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
